mips_cpu_muldiv: RTL and testbench

MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

---
 rtl/mips_cpu_muldiv.sv | 153 +++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Define MULDIV_FAST_MULT_EN to replace the iterative multiply with a single-cycle multiplier.
module mips_cpu_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    localparam logic [2:0] OpMult  = 3'd0;
    localparam logic [2:0] OpMultu = 3'd1;
    localparam logic [2:0] OpDiv   = 3'd2;
    localparam logic [2:0] OpDivu  = 3'd3;
    localparam logic [2:0] OpMthi  = 3'd4;
    localparam logic [2:0] OpMtlo  = 3'd5;

`ifdef MULDIV_FAST_MULT_EN
    localparam bit FastMult = 1'b1;
`else
    localparam bit FastMult = 1'b0;
`endif

    state_e      r_state;
    logic        r_busy, r_done;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_acc_hi, r_acc_lo, r_opnd;
    logic [4:0]  r_cnt;
    logic        r_is_div, r_neg_q, r_neg_r, r_div0;

    logic        w_signed, w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;
    logic [32:0] w_mul_sum, w_div_shift;
    logic        w_div_ge;
    logic [31:0] w_div_sub;
    logic [63:0] w_fast, w_prod, w_prod_fix;
    logic [31:0] w_quot, w_rem;

    always_comb begin
        w_signed    = (op == OpMult) || (op == OpDiv);
        w_a_neg     = w_signed & a[31];
        w_b_neg     = w_signed & b[31];
        w_a_mag     = w_a_neg ? (~a + 32'd1) : a;
        w_b_mag     = w_b_neg ? (~b + 32'd1) : b;
        // Multiply: {r_acc_hi, r_acc_lo} shifts right, multiplier bits consumed from r_acc_lo[0].
        w_mul_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : 33'd0);
        // Divide: partial remainder in r_acc_hi, dividend/quotient bits shift through r_acc_lo.
        w_div_shift = {r_acc_hi, r_acc_lo[31]};
        w_div_ge    = w_div_shift >= {1'b0, r_opnd};
        w_div_sub   = w_div_shift[31:0] - r_opnd;
        w_fast      = {32'd0, r_opnd} * {32'd0, r_acc_lo};
        w_prod      = {r_acc_hi, r_acc_lo};
        w_prod_fix  = r_neg_q ? (~w_prod + 64'd1) : w_prod;
        w_quot      = r_div0 ? 32'hFFFF_FFFF : (r_neg_q ? (~r_acc_lo + 32'd1) : r_acc_lo);
        w_rem       = r_neg_r ? (~r_acc_hi + 32'd1) : r_acc_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_acc_hi <= 32'd0;
            r_acc_lo <= 32'd0;
            r_opnd   <= 32'd0;
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        case (op)
                            OpMult, OpMultu: begin
                                r_opnd   <= w_a_mag;
                                r_acc_lo <= w_b_mag;
                                r_acc_hi <= 32'd0;
                                r_is_div <= 1'b0;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= 1'b0;
                                r_div0   <= 1'b0;
                                r_cnt    <= 5'd0;
                                r_busy   <= 1'b1;
                                r_state  <= StRun;
                            end
                            OpDiv, OpDivu: begin
                                r_opnd   <= w_b_mag;
                                r_acc_lo <= w_a_mag;
                                r_acc_hi <= 32'd0;
                                r_is_div <= 1'b1;
                                r_neg_q  <= w_a_neg ^ w_b_neg;
                                r_neg_r  <= w_a_neg;
                                r_div0   <= (b == 32'd0);
                                r_cnt    <= 5'd0;
                                r_busy   <= 1'b1;
                                r_state  <= StRun;
                            end
                            OpMthi:  r_hi <= a;
                            OpMtlo:  r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (FastMult && !r_is_div) begin
                        {r_acc_hi, r_acc_lo} <= w_fast;
                        r_state              <= StFin;
                    end else begin
                        if (r_is_div) begin
                            r_acc_hi <= w_div_ge ? w_div_sub : w_div_shift[31:0];
                            r_acc_lo <= {r_acc_lo[30:0], w_div_ge};
                        end else begin
                            r_acc_hi <= w_mul_sum[32:1];
                            r_acc_lo <= {w_mul_sum[0], r_acc_lo[31:1]};
                        end
                        if (r_cnt == 5'd31) begin
                            r_state <= StFin;
                        end
                    end
                end
                StFin: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed self-checking bench for mips_cpu_muldiv; honours MULDIV_FAST_MULT_EN for multiply latency.
module tb_mips_cpu_muldiv;
`ifdef MULDIV_FAST_MULT_EN
    localparam int LatMul = 2;
`else
    localparam int LatMul = 33;
`endif
    localparam int LatDiv = 33;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    mips_cpu_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) n_done <= n_done + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one op at edge 0 and returns just after the result edge (in the done cycle).
    // Scrambles a/b afterwards and injects a start while busy to prove both are ignored.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] ia,
                          input logic [31:0] ib, input logic [31:0] eh, input logic [31:0] el,
                          input int lat);
        logic [31:0] ph, pl;
        ph = hi;
        pl = lo;
        op = o; a = ia; b = ib; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ia;
        b = ib ^ 32'h5A5A_5A5A;
        chk({tag, "_busy_start"}, busy, 1);
        for (int i = 1; i < lat; i++) begin
            if (i == 1) begin
                start = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
            end
            tick();
            start = 1'b0;
        end
        chk({tag, "_busy_pre"}, busy, 1);
        chk({tag, "_done_pre"}, done, 0);
        chk({tag, "_hold"}, {hi, lo}, {ph, pl});
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
    endtask

    initial begin
        int d0;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);

        d0 = n_done;
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, LatMul);
        tick();
        chk("mult_neg_done_drop", done, 0);
        chk("mult_neg_pulses", n_done, d0 + 1);

        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
               LatMul);
        tick();
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LatDiv);
        tick();
        run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, LatDiv);
        tick();
        run_op("divu_by0", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, LatDiv);
        tick();
        run_op("div_by0_neg", 3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, LatDiv);
        tick();
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, LatDiv);
        tick();

        // MTHI then MTLO on consecutive edges
        d0 = n_done;
        start = 1'b1; op = 3'd4; a = 32'h1234_5678;
        tick();
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_busy", busy, 0);
        op = 3'd5; a = 32'h9ABC_DEF0;
        tick();
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("mtlo_hi_keep", hi, 32'h1234_5678);
        chk("mtlo_busy", busy, 0);
        chk("mtlo_done", done, 0);

        // Reserved ops
        start = 1'b1; op = 3'd6; a = 32'h1111_1111; b = 32'h2222_2222;
        tick();
        op = 3'd7;
        tick();
        start = 1'b0;
        tick();
        chk("rsvd_busy", busy, 0);
        chk("rsvd_hilo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});
        chk("mt_rsvd_pulses", n_done, d0);

        // DIVU 100/7, start while busy at cycle 5, reset at cycle 10
        d0 = n_done;
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) begin
            if (i == 5) begin
                start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
            end
            tick();
            start = 1'b0;
        end
        chk("abort_busy_pre", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        for (int i = 0; i < 40; i++) tick();
        chk("abort_no_done", n_done, d0);
        chk("abort_busy_late", busy, 0);

        // Back-to-back: DIVU issued in the MULTU done cycle
        d0 = n_done;
        run_op("b2b_multu", 3'd1, 32'd3, 32'd5, 32'd0, 32'd15, LatMul);
        run_op("b2b_divu", 3'd3, 32'd15, 32'd4, 32'd3, 32'd3, LatDiv);
        tick();
        chk("b2b_done_drop", done, 0);
        chk("b2b_pulses", n_done, d0 + 2);

        // Reset wins over start
        reset = 1'b1; start = 1'b1; op = 3'd4; a = 32'h5555_5555;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("rst_prio_hi", hi, 0);
        chk("rst_prio_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
